// File: rtl/pulse_check.sv
// pulse_check: measures a two-pulse timing sequence (q1 then q2) after an
// arm request. Reports the q1 high time, the q1-fall to q2-rise gap and the
// q2 high time, plus a result code for pass, timeout, order or overlap
// faults. Counters saturate, and every waiting state is bounded by a timeout.
module pulse_check #(
  parameter int W       = 8,
  parameter int TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sta,
  input  logic         q1,
  input  logic         q2,
  output logic         busy,
  output logic         done,
  output logic [1:0]   err_code,
  output logic [W-1:0] width1,
  output logic [W-1:0] gap,
  output logic [W-1:0] width2
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_PASS    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ORDER   = 2'd2;
  localparam logic [1:0] ERR_OVERLAP = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    HIGH1 = 3'd2,
    GAP   = 3'd3,
    HIGH2 = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_q1, r_q2;
  logic [W-1:0]  r_w1, r_gap, r_w2;
  logic [W-1:0]  w_w1_nxt, w_gap_nxt, w_w2_nxt;
  logic [1:0]    r_err, w_err_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          w_q1_rise, w_q1_fall, w_q2_rise, w_q2_fall;
  logic          w_tmo_hit, w_busy;

  // Saturating increment: measurement counters stick at all-ones.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + W'(1);
  endfunction

  assign w_q1_rise = q1 & ~r_q1;
  assign w_q1_fall = ~q1 & r_q1;
  assign w_q2_rise = q2 & ~r_q2;
  assign w_q2_fall = ~q2 & r_q2;

  // The counter reaches TIMEOUT on this edge when it currently holds TIMEOUT-1.
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  assign w_busy   = (r_state == ARM) || (r_state == HIGH1) ||
                    (r_state == GAP) || (r_state == HIGH2);
  assign busy     = w_busy;
  assign done     = (r_state == FIN);
  assign err_code = r_err;
  assign width1   = r_w1;
  assign gap      = r_gap;
  assign width2   = r_w2;

  // State, edge-detect copies, results and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_q1    <= 1'b0;
      r_q2    <= 1'b0;
      r_w1    <= '0;
      r_gap   <= '0;
      r_w2    <= '0;
      r_err   <= ERR_PASS;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q1    <= q1;
      r_q2    <= q2;
      r_w1    <= w_w1_nxt;
      r_gap   <= w_gap_nxt;
      r_w2    <= w_w2_nxt;
      r_err   <= w_err_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Next-state and result updates; timeout is checked before any edge event.
  always_comb begin
    w_state_nxt = r_state;
    w_w1_nxt    = r_w1;
    w_gap_nxt   = r_gap;
    w_w2_nxt    = r_w2;
    w_err_nxt   = r_err;
    w_tmo_nxt   = r_tmo;

    case (r_state)
      IDLE: begin
        if (sta) begin
          w_state_nxt = ARM;
          w_w1_nxt    = '0;
          w_gap_nxt   = '0;
          w_w2_nxt    = '0;
          w_err_nxt   = ERR_PASS;
        end
      end

      ARM: begin
        if (w_tmo_hit) begin
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = FIN;
        end else if (w_q1_rise && w_q2_rise) begin
          w_err_nxt   = ERR_OVERLAP;
          w_state_nxt = FIN;
        end else if (w_q2_rise) begin
          w_err_nxt   = ERR_ORDER;
          w_state_nxt = FIN;
        end else if (w_q1_rise) begin
          w_w1_nxt    = W'(1);
          w_state_nxt = HIGH1;
        end
      end

      HIGH1: begin
        if (w_tmo_hit) begin
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = FIN;
        end else if (q1 && w_q2_rise) begin
          // The overlapping cycle still counts as a q1 high cycle.
          w_w1_nxt    = sat_inc(r_w1);
          w_err_nxt   = ERR_OVERLAP;
          w_state_nxt = FIN;
        end else if (q1) begin
          w_w1_nxt    = sat_inc(r_w1);
        end else if (w_q1_fall) begin
          w_gap_nxt   = W'(1);
          w_state_nxt = GAP;
        end
      end

      GAP: begin
        if (w_tmo_hit) begin
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = FIN;
        end else if (w_q2_rise) begin
          w_w2_nxt    = W'(1);
          w_state_nxt = HIGH2;
        end else begin
          w_gap_nxt   = sat_inc(r_gap);
        end
      end

      HIGH2: begin
        if (w_tmo_hit) begin
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = FIN;
        end else if (q2) begin
          w_w2_nxt    = sat_inc(r_w2);
        end else if (w_q2_fall) begin
          w_err_nxt   = ERR_PASS;
          w_state_nxt = FIN;
        end
      end

      FIN: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Every state change restarts the timeout; dwelling in a busy state counts.
    if (w_state_nxt != r_state) begin
      w_tmo_nxt = '0;
    end else if (w_busy) begin
      w_tmo_nxt = r_tmo + TW'(1);
    end
  end

endmodule

// File: tb/tb_pulse_check.sv
// tb_pulse_check: directed sequences on two pulse_check instances. Stimulus
// pushes the expected result of each measurement into a per-instance queue;
// a monitor per instance pops and compares whenever done is seen.
module tb_pulse_check;

  logic clk = 1'b0;
  logic rst;
  logic sta_a, q1_a, q2_a, busy_a, done_a;
  logic sta_b, q1_b, q2_b, busy_b, done_b;
  logic [1:0] err_a, err_b;
  logic [7:0] w1_a, gap_a, w2_a;
  logic [3:0] w1_b, gap_b, w2_b;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int err;
    int w1;
    int gap;
    int w2;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  pulse_check #(.W(8), .TIMEOUT(10)) u_a (
    .clk(clk), .rst(rst), .sta(sta_a), .q1(q1_a), .q2(q2_a),
    .busy(busy_a), .done(done_a), .err_code(err_a),
    .width1(w1_a), .gap(gap_a), .width2(w2_a)
  );

  pulse_check #(.W(4), .TIMEOUT(30)) u_b (
    .clk(clk), .rst(rst), .sta(sta_b), .q1(q1_b), .q2(q2_b),
    .busy(busy_b), .done(done_b), .err_code(err_b),
    .width1(w1_b), .gap(gap_b), .width2(w2_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cmp_exp(input string tag, input exp_t e, input int err,
                         input int w1, input int g, input int w2);
    chk({tag, ".done_cycle"}, cyc, e.cyc);
    chk({tag, ".err_code"}, err, e.err);
    chk({tag, ".width1"}, w1, e.w1);
    chk({tag, ".gap"}, g, e.gap);
    chk({tag, ".width2"}, w2, e.w2);
  endtask

  // Monitor for instance A.
  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a.unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        cmp_exp("a", qa.pop_front(), int'(err_a), int'(w1_a), int'(gap_a), int'(w2_a));
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (done_b) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b.unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        cmp_exp("b", qb.pop_front(), int'(err_b), int'(w1_b), int'(gap_b), int'(w2_b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pass sequence on A: q1 high h1 cycles, g idle cycles, q2 high h2 cycles.
  task automatic nominal_a(input int h1, input int g, input int h2);
    sta_a = 1'b1;
    tick();
    sta_a = 1'b0;
    chk("a.busy_armed", int'(busy_a), 1);
    q1_a = 1'b1;
    repeat (h1) tick();
    q1_a = 1'b0;
    repeat (g) tick();
    q2_a = 1'b1;
    repeat (h2) tick();
    q2_a = 1'b0;
    qa.push_back('{0, h1, g, h2, cyc + 1});
    tick();
    tick();
    chk("a.busy_after_done", int'(busy_a), 0);
  endtask

  initial begin
    rst = 1'b1;
    sta_a = 1'b0; q1_a = 1'b0; q2_a = 1'b0;
    sta_b = 1'b1; q1_b = 1'b0; q2_b = 1'b0;
    tick();
    tick();
    // sta held high on B during reset must not arm it.
    chk("a.rst_busy", int'(busy_a), 0);
    chk("a.rst_done", int'(done_a), 0);
    chk("a.rst_err", int'(err_a), 0);
    chk("a.rst_width1", int'(w1_a), 0);
    chk("a.rst_gap", int'(gap_a), 0);
    chk("a.rst_width2", int'(w2_a), 0);
    chk("b.rst_busy", int'(busy_b), 0);
    chk("b.rst_done", int'(done_b), 0);
    sta_b = 1'b0;
    rst = 1'b0;
    tick();

    // Nominal: 3 / 2 / 4.
    nominal_a(3, 2, 4);

    // Order error: q2 rises first.
    sta_a = 1'b1;
    tick();
    sta_a = 1'b0;
    q2_a = 1'b1;
    qa.push_back('{2, 0, 0, 0, cyc + 1});
    tick();
    q2_a = 1'b0;
    tick();
    tick();
    chk("a.busy_after_order", int'(busy_a), 0);

    // Overlap: q2 rises on the third q1 high cycle.
    sta_a = 1'b1;
    tick();
    sta_a = 1'b0;
    q1_a = 1'b1;
    tick();
    tick();
    q2_a = 1'b1;
    qa.push_back('{3, 3, 0, 0, cyc + 1});
    tick();
    tick();
    tick();
    q1_a = 1'b0;
    q2_a = 1'b0;
    tick();
    tick();

    // Timeout in ARM: done 10 cycles after ARM entry.
    sta_a = 1'b1;
    qa.push_back('{1, 0, 0, 0, cyc + 11});
    tick();
    sta_a = 1'b0;
    repeat (5) tick();
    chk("a.busy_waiting", int'(busy_a), 1);
    repeat (8) tick();
    chk("a.busy_after_timeout", int'(busy_a), 0);

    // Reset while in GAP discards the measurement.
    sta_a = 1'b1;
    tick();
    sta_a = 1'b0;
    q1_a = 1'b1;
    tick();
    q1_a = 1'b0;
    tick();
    tick();
    chk("a.gap_before_rst", int'(gap_a), 2);
    chk("a.width1_before_rst", int'(w1_a), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("a.midrst_busy", int'(busy_a), 0);
    chk("a.midrst_done", int'(done_a), 0);
    chk("a.midrst_err", int'(err_a), 0);
    chk("a.midrst_width1", int'(w1_a), 0);
    chk("a.midrst_gap", int'(gap_a), 0);
    chk("a.midrst_width2", int'(w2_a), 0);
    tick();
    nominal_a(2, 1, 1);

    // B: width1 and gap saturate at 15; sta during HIGH1 is ignored.
    sta_b = 1'b1;
    tick();
    sta_b = 1'b0;
    q1_b = 1'b1;
    repeat (5) tick();
    sta_b = 1'b1;
    tick();
    sta_b = 1'b0;
    repeat (14) tick();
    chk("b.busy_high1", int'(busy_b), 1);
    q1_b = 1'b0;
    repeat (17) tick();
    q2_b = 1'b1;
    repeat (3) tick();
    q2_b = 1'b0;
    qb.push_back('{0, 15, 15, 3, cyc + 1});
    tick();
    tick();
    chk("b.busy_after_done", int'(busy_b), 0);

    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    chk("pending_done_pulses", qa.size() + qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
